// File: rtl/uart_line_rx.sv
// UART 8N1 receiver with a NUL-terminated line assembler and a registered random-access read port.
// Optional even-parity reception is enabled by defining UART_LINE_PARITY_EN.
module uart_line_rx #(
  parameter int          CLKS_PER_BIT = 5625,
  parameter int          BUF_DEPTH    = 64,
  parameter logic [7:0]  TERM_CHAR    = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_pin,
  output logic                         byte_valid,
  output logic [7:0]                   byte_data,
  output logic                         line_valid,
  output logic [$clog2(BUF_DEPTH):0]   line_len,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         line_ack,
  output logic                         frame_err,
  output logic                         overflow,
  output logic                         parity_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(BUF_DEPTH);

`ifdef UART_LINE_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
`endif
  typedef enum logic {A_FILL, A_HOLD} asm_state_t;

  rx_state_t  r_rx_state, w_rx_next;
  asm_state_t r_asm_state, w_asm_next;

  logic          r_rx_meta, r_rx_sync;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          w_tick, w_stop_sample, w_good, w_ferr, w_perr;
`ifdef UART_LINE_PARITY_EN
  logic          r_par_bit;
`endif

  logic          r_byte_valid, r_frame_err, r_parity_err, r_overflow, r_line_valid;
  logic [7:0]    r_byte_data, r_rd_data;
  logic [LW-1:0] r_wr_idx, r_line_len;
  logic [7:0]    r_buf [BUF_DEPTH];
  logic          w_is_term, w_full, w_wr_en, w_close, w_release, w_ovf;

  // Two-flop synchroniser; resets to idle-high so reset release never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_pin;
      r_rx_sync <= r_rx_meta;
    end
  end

  // START waits half a bit to land on the start-bit centre; later states wait a full bit
  assign w_tick = (r_rx_state == S_START) ? (r_clk_cnt == HALF_M1) : (r_clk_cnt == FULL_M1);

  // Rx state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= S_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  // Rx next-state logic
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (!r_rx_sync) w_rx_next = S_START; else w_rx_next = S_IDLE;
      S_START:  if (w_tick) w_rx_next = r_rx_sync ? S_IDLE : S_DATA; else w_rx_next = S_START;
`ifdef UART_LINE_PARITY_EN
      S_DATA:   if (w_tick && (r_bit_cnt == 3'd7)) w_rx_next = S_PARITY; else w_rx_next = S_DATA;
      S_PARITY: if (w_tick) w_rx_next = S_STOP; else w_rx_next = S_PARITY;
`else
      S_DATA:   if (w_tick && (r_bit_cnt == 3'd7)) w_rx_next = S_STOP; else w_rx_next = S_DATA;
`endif
      S_STOP:   if (w_tick) w_rx_next = S_IDLE; else w_rx_next = S_STOP;
      default:  w_rx_next = S_IDLE;
    endcase
  end

  // Rx output decode at the stop-bit sample
  always_comb begin
    w_stop_sample = (r_rx_state == S_STOP) && w_tick;
`ifdef UART_LINE_PARITY_EN
    w_perr = w_stop_sample && ((^r_shift) != r_par_bit);
`else
    w_perr = 1'b0;
`endif
    w_ferr = w_stop_sample && !r_rx_sync;
    w_good = w_stop_sample && r_rx_sync && !w_perr;
  end

  // Rx bit timing and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt <= {CW{1'b0}};
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
`ifdef UART_LINE_PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else begin
      if ((r_rx_state == S_IDLE) || w_tick) begin
        r_clk_cnt <= {CW{1'b0}};
      end else begin
        r_clk_cnt <= r_clk_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
      if (r_rx_state == S_IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if ((r_rx_state == S_DATA) && w_tick) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {r_rx_sync, r_shift[7:1]};
      end
`ifdef UART_LINE_PARITY_EN
      if ((r_rx_state == S_PARITY) && w_tick) begin
        r_par_bit <= r_rx_sync;
      end
`endif
    end
  end

  // Registered receive pulses; byte_data holds the last good byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_byte_valid <= w_good;
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      if (w_good) begin
        r_byte_data <= r_shift;
      end
    end
  end

  assign w_is_term = (r_byte_data == TERM_CHAR);
  assign w_full    = (r_wr_idx == DEPTH_L);

  // Assembler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_state <= A_FILL;
    end else begin
      r_asm_state <= w_asm_next;
    end
  end

  // Assembler next-state logic
  always_comb begin
    w_asm_next = r_asm_state;
    case (r_asm_state)
      A_FILL:  if (r_byte_valid && w_is_term) w_asm_next = A_HOLD; else w_asm_next = A_FILL;
      A_HOLD:  if (line_ack) w_asm_next = A_FILL; else w_asm_next = A_HOLD;
      default: w_asm_next = A_FILL;
    endcase
  end

  // Assembler actions; a byte arriving with the ack in HOLD is still dropped
  always_comb begin
    w_close   = (r_asm_state == A_FILL) && r_byte_valid && w_is_term;
    w_wr_en   = (r_asm_state == A_FILL) && r_byte_valid && !w_is_term && !w_full;
    w_release = (r_asm_state == A_HOLD) && line_ack;
    w_ovf     = r_byte_valid && ((r_asm_state == A_HOLD) || (!w_is_term && w_full));
  end

  // Write index, line length and line status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx     <= {LW{1'b0}};
      r_line_len   <= {LW{1'b0}};
      r_line_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= w_ovf;
      if (w_release) begin
        r_wr_idx     <= {LW{1'b0}};
        r_line_valid <= 1'b0;
      end else if (w_close) begin
        r_line_len   <= r_wr_idx;
        r_line_valid <= 1'b1;
      end else if (w_wr_en) begin
        r_wr_idx <= r_wr_idx + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Line buffer storage, contents undefined after reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_idx[AW-1:0]] <= r_byte_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_buf[rd_addr];
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign line_valid = r_line_valid;
  assign line_len   = r_line_len;
  assign rd_data    = r_rd_data;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx: a 64-byte instance and a 4-byte instance at 16 clocks per bit.
module tb_uart_line_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic tx_line = 1'b1;
  logic tx_sel = 1'b0;
  logic rx_a, rx_b;
  assign rx_a = tx_sel ? 1'b1 : tx_line;
  assign rx_b = tx_sel ? tx_line : 1'b1;

  logic       bv_a, lv_a, fe_a, ov_a, pe_a, ack_a = 1'b0;
  logic [7:0] bd_a, rd_a;
  logic [6:0] ll_a;
  logic [5:0] ra_a = 6'd0;
  logic       bv_b, lv_b, fe_b, ov_b, pe_b, ack_b = 1'b0;
  logic [7:0] bd_b, rd_b;
  logic [2:0] ll_b;
  logic [1:0] ra_b = 2'd0;

  uart_line_rx #(.CLKS_PER_BIT(CPB), .BUF_DEPTH(64), .TERM_CHAR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_a), .byte_valid(bv_a), .byte_data(bd_a),
    .line_valid(lv_a), .line_len(ll_a), .rd_addr(ra_a), .rd_data(rd_a), .line_ack(ack_a),
    .frame_err(fe_a), .overflow(ov_a), .parity_err(pe_a));

  uart_line_rx #(.CLKS_PER_BIT(CPB), .BUF_DEPTH(4), .TERM_CHAR(8'h00)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_b), .byte_valid(bv_b), .byte_data(bd_b),
    .line_valid(lv_b), .line_len(ll_b), .rd_addr(ra_b), .rd_data(rd_b), .line_ack(ack_b),
    .frame_err(fe_b), .overflow(ov_b), .parity_err(pe_b));

  int checks = 0;
  int errors = 0;
  int nbv_a = 0, nfe_a = 0, nov_a = 0, npe_a = 0;
  int nbv_b = 0, nov_b = 0, npe_b = 0;
  logic [7:0] log_a [$];

  // Pulse counters: each high cycle is counted once
  always @(posedge clk) begin
    if (bv_a) begin nbv_a <= nbv_a + 1; log_a.push_back(bd_a); end
    if (fe_a) nfe_a <= nfe_a + 1;
    if (ov_a) nov_a <= nov_a + 1;
    if (pe_a) npe_a <= npe_a + 1;
    if (bv_b) nbv_b <= nbv_b + 1;
    if (ov_b) nov_b <= nov_b + 1;
    if (pe_b) npe_b <= npe_b + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    tx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_LINE_PARITY_EN
    tx_line = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    tx_line = stop_bit;
    repeat (CPB) @(negedge clk);
    tx_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic ack_line_a();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bv_a, fe_a, ov_a, pe_a, lv_a, ll_a, rd_a, bd_a} !== 28'd0) begin
      errors++; $display("FAIL reset_outputs_a got %h want 0", {bv_a, fe_a, ov_a, pe_a, lv_a, ll_a, rd_a, bd_a});
    end
    checks++;
    if ({bv_b, lv_b, ll_b, ov_b} !== 6'd0) begin
      errors++; $display("FAIL reset_outputs_b got %h want 0", {bv_b, lv_b, ll_b, ov_b});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({lv_a, ll_a, bv_a} !== 9'd0) begin
      errors++; $display("FAIL after_reset got %h want 0", {lv_a, ll_a, bv_a});
    end
  endtask

  task automatic test_hello();
    logic [7:0] msg [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00};
    int bv0 = nbv_a;
    int lg0 = log_a.size();
    for (int i = 0; i < 6; i++) send_byte(msg[i], 1'b1, 1'b0);
    checks++;
    if (nbv_a - bv0 !== 6) begin errors++; $display("FAIL hello_byte_valid got %0d want 6", nbv_a - bv0); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_a[lg0 + i] !== msg[i]) begin
        errors++; $display("FAIL hello_byte_data[%0d] got %h want %h", i, log_a[lg0 + i], msg[i]);
      end
    end
    checks++;
    if (lv_a !== 1'b1 || ll_a !== 7'd5) begin
      errors++; $display("FAIL hello_line got valid=%b len=%0d want valid=1 len=5", lv_a, ll_a);
    end
    for (int i = 0; i < 5; i++) begin
      ra_a = 6'(i);
      @(negedge clk);
      checks++;
      if (rd_a !== msg[i]) begin errors++; $display("FAIL hello_rd[%0d] got %h want %h", i, rd_a, msg[i]); end
    end
  endtask

  task automatic test_ack_next_line();
    ack_line_a();
    checks++;
    if (lv_a !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", lv_a); end
    send_byte(8'h48, 1'b1, 1'b0);
    send_byte(8'h69, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    checks++;
    if (lv_a !== 1'b1 || ll_a !== 7'd2) begin
      errors++; $display("FAIL hi_line got valid=%b len=%0d want valid=1 len=2", lv_a, ll_a);
    end
    ra_a = 6'd0; @(negedge clk);
    checks++;
    if (rd_a !== 8'h48) begin errors++; $display("FAIL hi_rd0 got %h want 48", rd_a); end
    ra_a = 6'd1; @(negedge clk);
    checks++;
    if (rd_a !== 8'h69) begin errors++; $display("FAIL hi_rd1 got %h want 69", rd_a); end
  endtask

  task automatic test_frame_error();
    int bv0, fe0;
    ack_line_a();
    bv0 = nbv_a; fe0 = nfe_a;
    send_byte(8'h41, 1'b0, 1'b0);
    checks++;
    if (nfe_a - fe0 !== 1 || nbv_a !== bv0) begin
      errors++; $display("FAIL frame_err got fe=%0d bv=%0d want fe=1 bv=0", nfe_a - fe0, nbv_a - bv0);
    end
    send_byte(8'h42, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    ra_a = 6'd0; @(negedge clk);
    checks++;
    if (ll_a !== 7'd1 || rd_a !== 8'h42) begin
      errors++; $display("FAIL frame_err_recover got len=%0d rd0=%h want len=1 rd0=42", ll_a, rd_a);
    end
  endtask

  task automatic test_glitch();
    int bv0, fe0, ov0;
    ack_line_a();
    bv0 = nbv_a; fe0 = nfe_a; ov0 = nov_a;
    tx_line = 1'b0;
    repeat (4) @(negedge clk);
    tx_line = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (nbv_a != bv0 || nfe_a != fe0 || nov_a != ov0) begin
      errors++; $display("FAIL glitch got bv=%0d fe=%0d ov=%0d want 0 0 0", nbv_a - bv0, nfe_a - fe0, nov_a - ov0);
    end
    send_byte(8'h55, 1'b1, 1'b0);
    checks++;
    if (nbv_a - bv0 !== 1 || bd_a !== 8'h55) begin
      errors++; $display("FAIL glitch_recover got n=%0d byte=%h want n=1 byte=55", nbv_a - bv0, bd_a);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] msg [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h00};
    int ov0 = nov_b;
    tx_sel = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(msg[i], 1'b1, 1'b0);
    checks++;
    if (nov_b - ov0 !== 1 || lv_b !== 1'b1 || ll_b !== 3'd4) begin
      errors++; $display("FAIL ovf_line got ov=%0d valid=%b len=%0d want ov=1 valid=1 len=4", nov_b - ov0, lv_b, ll_b);
    end
    send_byte(8'h46, 1'b1, 1'b0);
    checks++;
    if (nov_b - ov0 !== 2 || ll_b !== 3'd4) begin
      errors++; $display("FAIL ovf_hold got ov=%0d len=%0d want ov=2 len=4", nov_b - ov0, ll_b);
    end
    for (int i = 0; i < 4; i++) begin
      ra_b = 2'(i);
      @(negedge clk);
      checks++;
      if (rd_b !== msg[i]) begin errors++; $display("FAIL ovf_rd[%0d] got %h want %h", i, rd_b, msg[i]); end
    end
    tx_sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int bv0, fe0, ov0;
    send_byte(8'h41, 1'b1, 1'b0);
    tx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    tx_line = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bv_a, fe_a, ov_a, pe_a, lv_a, ll_a, rd_a, bd_a} !== 28'd0) begin
      errors++; $display("FAIL mid_reset_outputs got %h want 0", {bv_a, fe_a, ov_a, pe_a, lv_a, ll_a, rd_a, bd_a});
    end
    tx_line = 1'b1;
    repeat (2) @(negedge clk);
    bv0 = nbv_a; fe0 = nfe_a; ov0 = nov_a;
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++;
    if (nbv_a != bv0 || nfe_a != fe0 || nov_a != ov0) begin
      errors++; $display("FAIL mid_reset_quiet got bv=%0d fe=%0d ov=%0d want 0 0 0", nbv_a - bv0, nfe_a - fe0, nov_a - ov0);
    end
    send_byte(8'h43, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    ra_a = 6'd0; @(negedge clk);
    checks++;
    if (lv_a !== 1'b1 || ll_a !== 7'd1 || rd_a !== 8'h43) begin
      errors++; $display("FAIL mid_reset_line got valid=%b len=%0d rd0=%h want 1 1 43", lv_a, ll_a, rd_a);
    end
  endtask

  task automatic test_parity();
    int pe0 = npe_a;
    int bv0;
    ack_line_a();
    bv0 = nbv_a;
`ifdef UART_LINE_PARITY_EN
    send_byte(8'h41, 1'b1, 1'b1);
    checks++;
    if (npe_a - pe0 !== 1 || nbv_a != bv0) begin
      errors++; $display("FAIL parity_err got pe=%0d bv=%0d want pe=1 bv=0", npe_a - pe0, nbv_a - bv0);
    end
    send_byte(8'h41, 1'b1, 1'b0);
    checks++;
    if (npe_a - pe0 !== 1 || nbv_a - bv0 !== 1 || bd_a !== 8'h41) begin
      errors++; $display("FAIL parity_good got pe=%0d bv=%0d byte=%h want 1 1 41", npe_a - pe0, nbv_a - bv0, bd_a);
    end
`else
    send_byte(8'h41, 1'b1, 1'b0);
    checks++;
    if (npe_a !== 0 || npe_b !== 0 || nbv_a - bv0 !== 1 || bd_a !== 8'h41) begin
      errors++; $display("FAIL no_parity got pe=%0d/%0d bv=%0d byte=%h want 0/0 1 41", npe_a, npe_b, nbv_a - bv0, bd_a);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hello();
    test_ack_next_line();
    test_frame_error();
    test_glitch();
    test_overflow();
    test_reset_mid_frame();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_line_rx.md
Name: uart_line_rx

Overview:
Serial-in UART receiver plus line assembler: the receiving end of the board's NUL-terminated string transmitter. Deserialises 8N1 frames from rx_pin and collects good bytes into an internal line buffer until TERM_CHAR arrives. It then presents the complete line through a random-access read port until the consumer acknowledges it. Sits between the rx pin and command/console logic.

Parameters:
CLKS_PER_BIT, 5625, clk cycles per UART bit (27 MHz / 4800 baud); minimum 4
BUF_DEPTH, 64, line buffer bytes; power of two, 4..256
TERM_CHAR, 8'h00, line terminator byte; not stored in the buffer

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
rx_pin  input  1  asynchronous serial input, idle high
byte_valid  output  1  one-cycle pulse per good received byte
byte_data  output  8  last good byte; valid while byte_valid is high, held otherwise
line_valid  output  1  complete line held in buffer
line_len  output  $clog2(BUF_DEPTH)+1  byte count of held line, excluding terminator
rd_addr  input  $clog2(BUF_DEPTH)  buffer read address
rd_data  output  8  buffer[rd_addr], registered, 1-cycle latency
line_ack  input  1  consumer releases the line; sampled only while line_valid=1
frame_err  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  one-cycle pulse: good byte dropped (buffer full or line held)
parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; rx FSM in IDLE; write index 0; assembler in FILL. Buffer contents are undefined after reset.
- rx_pin passes through a 2-FF synchroniser. The FSM uses only the synchronised value, which adds 2 cycles of latency.
- Rx FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronised rx = 0 -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 0 -> DATA. If 1 -> glitch; go to IDLE with no pulses.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, LSB first. After 8 samples -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1 -> good byte: byte_valid pulses for 1 cycle with byte_data and the byte is offered to the assembler. If 0 -> frame_err pulses and the byte is discarded. Either way -> IDLE in the same cycle.
  - A back-to-back start bit is accepted; no idle time is required beyond the stop-bit centre.
- Assembler states: FILL, HOLD.
  - FILL, good byte == TERM_CHAR: line_len <= write index, line_valid <= 1 next cycle, -> HOLD. The terminator is not written.
  - FILL, good byte != TERM_CHAR, index < BUF_DEPTH: write buffer[index] and increment the index.
  - FILL, good byte != TERM_CHAR, index == BUF_DEPTH: byte dropped, overflow pulses, index unchanged. The line keeps the first BUF_DEPTH bytes and closes at the next terminator.
  - FILL with an empty line: terminator at index 0 gives line_valid with line_len = 0.
  - HOLD: every good byte, including the terminator, is dropped and overflow pulses. Buffer and line_len are frozen.
  - HOLD, line_ack = 1: next cycle line_valid = 0, index = 0, -> FILL.
  - line_ack and a good byte in the same HOLD cycle: the ack wins and the byte is dropped with an overflow pulse.
  - line_ack in FILL is ignored.
- rd_data is registered every cycle from buffer[rd_addr]. Addresses >= line_len return stale contents with no error.
- Reset mid-frame or mid-line: immediately abandons the frame and the line. No pulses are emitted as a result.

Optional Feature:
UART_LINE_PARITY_EN
- Defined: an even-parity bit is expected between bit 7 and the stop bit, adding a PARITY state. On mismatch, parity_err pulses at the stop-bit sample, the byte is discarded and byte_valid stays low. If parity and stop are both bad, frame_err and parity_err pulse in the same cycle.
- Undefined: no PARITY state; parity_err is tied 0.

Test Plan:
1. CLKS_PER_BIT=16, BUF_DEPTH=64. Send 48 65 6C 6C 6F 00 -> 6 byte_valid pulses, then line_valid=1 and line_len=5. rd_addr 0..4 returns 48 65 6C 6C 6F, each one cycle after the address.
2. Following test 1, pulse line_ack, then send 48 69 00 -> line_valid drops next cycle, then rises with line_len=2, buffer 48 69.
3. Send 0x41 with stop bit = 0 -> frame_err single pulse, no byte_valid, write index unchanged. The next good 0x42 is stored at index 0.
4. Drive rx_pin low for 4 clocks, then high -> no byte_valid, frame_err or overflow; FSM returns to IDLE. A following 0x55 is received correctly.
5. BUF_DEPTH=4, send 41 42 43 44 45 00 -> overflow pulses on 0x45, line_len=4, buffer 41 42 43 44. Then send 0x46 in HOLD -> overflow pulse, buffer unchanged.
6. Assert rst_n during DATA of the second byte of "AB" -> all outputs 0 and index 0. Sending 43 00 then gives line_len=1, buffer[0]=43. With UART_LINE_PARITY_EN, 0x41 with parity=1 -> parity_err pulse, byte discarded.
